seq_divider: RTL

//  Sequential restoring divider; the inverse of the N x N -> 2N multiplier path.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 42 ++++
 rtl/seq_divider.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential restoring divider.
//   - DIV_N   : default operand width (divisor, quotient, remainder).
//   - state_t : controller state encoding, shared with anything that observes
//               the divider's state (debug taps, formal harnesses).
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for an operation; in_ready is high
    CALC = 2'd1,  // one restoring step per cycle
    DONE = 2'd2   // result presented; waiting for out_ready
  } state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step.
//   The partial remainder is shifted left by one and the next dividend bit is
//   brought in (t = {rem, msb_in}); if t is at least the divisor, the divisor
//   is subtracted and the quotient bit is 1, otherwise t is kept and the bit
//   is 0.
//
// Ports
//   rem      in  N  current partial remainder (always < divisor)
//   msb_in   in  1  next dividend bit shifted into the remainder
//   divisor  in  N  divisor (non-zero whenever the result is used)
//   rem_next out N  partial remainder after this step
//   qbit     out 1  quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] rem,
  input  logic         msb_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_next,
  output logic         qbit
);

  logic [N:0] t;
  logic [N:0] diff;

  assign t    = {rem, msb_in};
  assign diff = t - {1'b0, divisor};
  assign qbit = (t >= {1'b0, divisor});

  // With rem < divisor, t < 2*divisor, so t - divisor < divisor and the
  // subtraction result always fits N bits; the dropped top bit is zero.
  assign rem_next = qbit ? diff[N-1:0] : t[N-1:0];

  // The top bit of diff carries no information in the kept result; fold it
  // into a dead net so it is visibly accounted for.
  logic unused_diff_msb;
  assign unused_diff_msb = diff[N];

endmodule : div_step

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Sequential restoring divider: 2N-bit unsigned dividend / N-bit unsigned
//   divisor -> N-bit quotient and N-bit remainder, one quotient bit per cycle.
//   Companion to the N x N -> 2N multiplier; a product fed back here with the
//   same multiplicand returns the other operand.
//
//   Division by zero and quotient overflow (dividend[2N-1:N] >= divisor) are
//   detected at accept time and answered directly with quotient = all ones,
//   remainder = dividend[N-1:0] and the matching flag set.
//
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   synchronous, active-high; aborts any operation
//   in_valid     in   1   dividend/divisor valid
//   in_ready     out  1   operation can be accepted (high only in IDLE)
//   dividend     in   2N  numerator, unsigned
//   divisor      in   N   denominator, unsigned
//   out_valid    out  1   result valid, held until out_ready
//   out_ready    in   1   consumer accepts result
//   quotient     out  N   unsigned quotient
//   remainder    out  N   unsigned remainder
//   div_by_zero  out  1   divisor was zero
//   overflow     out  1   quotient would not fit N bits
//
// Timing
//   Normal result : out_valid rises on the N-th rising edge after acceptance.
//   Flagged result: registered on the accepting edge itself, so out_valid is
//                   high on the very next cycle.
//   N must be at least 2.
// -----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int              CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           next_state;

  logic [N-1:0]     rem_reg;     // partial remainder
  logic [N-1:0]     q_reg;       // low dividend bits shifting out, quotient in
  logic [N-1:0]     div_reg;     // captured divisor
  logic [CNT_W-1:0] count;       // steps completed in CALC

  logic [N-1:0]     step_rem;
  logic             step_qbit;

  logic             accept;
  logic             zero_divisor;
  logic             quot_overflow;
  logic             last_step;
  logic             result_taken;

  // ---------------------------------------------------------------------------
  // Decode of the accept-time cases and the end of iteration
  // ---------------------------------------------------------------------------
  assign accept        = in_valid && (state == IDLE);
  assign zero_divisor  = (divisor == '0);
  // The quotient fits N bits exactly when the upper dividend half is below
  // the divisor; this is also what keeps rem < divisor from the first step.
  assign quot_overflow = (dividend[2*N-1:N] >= divisor);
  assign last_step     = (state == CALC) && (count == LAST_STEP);
  assign result_taken  = (state == DONE) && out_ready;

  // ---------------------------------------------------------------------------
  // Single restoring step, fed from the working registers
  // ---------------------------------------------------------------------------
  div_step #(.N(N)) u_step (
    .rem      (rem_reg),
    .msb_in   (q_reg[N-1]),
    .divisor  (div_reg),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge only (synchronous), so it sits
  // inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next_state is given a default before the case so every path assigns
  // it; without that, an unlisted path would infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          next_state = (zero_divisor || quot_overflow) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (result_taken) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Working registers: remainder, shifting quotient, divisor, step counter
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, exactly like the flops it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_reg <= '0;
      q_reg   <= '0;
      div_reg <= '0;
      count   <= '0;
    end else begin
      if (accept && !zero_divisor && !quot_overflow) begin
        rem_reg <= dividend[2*N-1:N];
        q_reg   <= dividend[N-1:0];
        div_reg <= divisor;
        count   <= '0;
      end else if (state == CALC) begin
        rem_reg <= step_rem;
        q_reg   <= {q_reg[N-2:0], step_qbit};
        // Stop at the last step so the counter never wraps mid-operation.
        if (!last_step) begin
          count <= count + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: loaded once per operation, held otherwise so the
  // presented result stays stable while the consumer stalls and after it
  // has been taken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept && (zero_divisor || quot_overflow)) begin
      quotient    <= '1;
      remainder   <= dividend[N-1:0];
      div_by_zero <= zero_divisor;
      overflow    <= !zero_divisor;
    end else if (last_step) begin
      quotient    <= {q_reg[N-2:0], step_qbit};
      remainder   <= step_rem;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end
  end

endmodule : seq_divider
